pio_result_tx: RTL and testbench



---
 rtl/pio_tx_pkg.sv | 18 +
 rtl/pio_tx_fifo.sv | 57 +++++
 rtl/pio_result_tx.sv | 140 ++++++++++++++
 tb/tb_pio_result_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_tx_pkg.sv
// Shared types and constants for the PIO result transmitter: FSM states,
// PIO bit positions and the fixed PIO word widths.
package pio_tx_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } tx_state_e;

    localparam int SEQ_BIT   = 15;
    localparam int LAST_BIT  = 14;
    localparam int ACK_BIT   = 31;
    localparam int FLUSH_BIT = 30;

    localparam int PIO_OUT_W = 16;
    localparam int PIO_IN_W  = 32;

endpackage

// File: rtl/pio_tx_fifo.sv
// Synchronous FIFO with registered storage, wrap-bit pointers and a flush that
// drops every queued entry (flush beats push and pop in the same cycle).
module pio_tx_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    // Read/write pointer update; a flush catches the read pointer up to the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Entry storage written on an accepted push.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/pio_result_tx.sv
// Result transmitter to the HPS over a PIO pair using a SEQ/ACK toggle handshake.
// Optional feature macro: PIO_TX_FLUSH_EN (HPS-driven FIFO flush on pio_in[30]).
module pio_result_tx
    import pio_tx_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_last,
    input  logic [PIO_IN_W-1:0]  pio_in,
    output logic [PIO_OUT_W-1:0] pio_out
);

    localparam int ENTRY_W = DATA_W + 1;

    logic [1:0]           r_ack_sync;
    logic                 w_ack_s;
    logic                 w_flush;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_seq;
    logic [ENTRY_W-1:0]   w_rd_entry;
    tx_state_e            r_state;
    tx_state_e            w_state_nxt;
    logic [PIO_OUT_W-1:0] r_pio_out;
    logic [PIO_OUT_W-1:0] w_pio_nxt;
    logic                 w_unused;

    // Two-flop synchroniser for the HPS ACK bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_sync <= 2'b00;
        end else begin
            r_ack_sync <= {r_ack_sync[0], pio_in[ACK_BIT]};
        end
    end

    assign w_ack_s = r_ack_sync[1];

`ifdef PIO_TX_FLUSH_EN
    logic [2:0] r_flush_sync;

    // Flush synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_sync <= 3'b000;
        end else begin
            r_flush_sync <= {r_flush_sync[1:0], pio_in[FLUSH_BIT]};
        end
    end

    assign w_flush  = r_flush_sync[1] & ~r_flush_sync[2];
    assign w_unused = ^pio_in[FLUSH_BIT-1:0];
`else
    assign w_flush  = 1'b0;
    assign w_unused = ^pio_in[FLUSH_BIT:0];
`endif

    assign in_ready = ~w_full;
    assign w_push   = in_valid & ~w_full;
    assign w_seq    = r_pio_out[SEQ_BIT];
    assign pio_out  = r_pio_out;

    pio_tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata ({in_last, in_data}),
        .o_rdata (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Handshake FSM: next state, next PIO word and FIFO pop request.
    always_comb begin
        w_state_nxt = r_state;
        w_pio_nxt   = r_pio_out;
        w_pop       = 1'b0;
        if (w_flush) begin
            // Nothing pending afterwards: SEQ follows the current ACK.
            w_state_nxt        = IDLE;
            w_pio_nxt          = {PIO_OUT_W{1'b0}};
            w_pio_nxt[SEQ_BIT] = w_ack_s;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        w_pop                 = 1'b1;
                        w_pio_nxt[SEQ_BIT]    = ~w_seq;
                        w_pio_nxt[LAST_BIT:0] = w_rd_entry;
                        w_state_nxt           = WAIT_ACK;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                WAIT_ACK: begin
                    if (w_ack_s == w_seq) begin
                        if (!w_empty) begin
                            w_pop                 = 1'b1;
                            w_pio_nxt[SEQ_BIT]    = ~w_seq;
                            w_pio_nxt[LAST_BIT:0] = w_rd_entry;
                            w_state_nxt           = WAIT_ACK;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_state_nxt = WAIT_ACK;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and PIO output register; all 16 PIO bits update on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pio_out <= {PIO_OUT_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_pio_out <= w_pio_nxt;
        end
    end

endmodule

// File: tb/tb_pio_result_tx.sv
// Self-checking bench for pio_result_tx: directed steps plus random traffic
// compared against a queue-based model of the SEQ/ACK transfer rules.
module tb_pio_result_tx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_data;
    logic        in_last;
    logic [31:0] pio_in;
    logic [15:0] pio_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [14:0] m_q[$];
    logic        m_seq;
    logic        m_idle;
    logic [15:0] m_pio;
    logic [1:0]  m_ack_pipe;
`ifdef PIO_TX_FLUSH_EN
    logic [2:0]  m_fl_pipe;
`endif

    pio_result_tx #(.DATA_W(14), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .pio_in   (pio_in),
        .pio_out  (pio_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_seq      = 1'b0;
        m_idle     = 1'b1;
        m_pio      = 16'h0000;
        m_ack_pipe = 2'b00;
`ifdef PIO_TX_FLUSH_EN
        m_fl_pipe  = 3'b000;
`endif
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic tick();
        logic        ack_s;
        logic        flush;
        logic        push_ok;
        logic [14:0] head;
        ack_s = m_ack_pipe[1];
        flush = 1'b0;
`ifdef PIO_TX_FLUSH_EN
        flush     = m_fl_pipe[1] & ~m_fl_pipe[2];
        m_fl_pipe = {m_fl_pipe[1:0], pio_in[30]};
`endif
        m_ack_pipe = {m_ack_pipe[0], pio_in[31]};
        push_ok    = in_valid && (m_q.size() < DEPTH);
        if (flush) begin
            m_q.delete();
            m_idle = 1'b1;
            m_seq  = ack_s;
            m_pio  = {ack_s, 15'h0000};
        end else begin
            if ((m_idle || ack_s == m_seq) && m_q.size() != 0) begin
                head   = m_q.pop_front();
                m_seq  = ~m_seq;
                m_pio  = {m_seq, head};
                m_idle = 1'b0;
            end else if (!m_idle && ack_s == m_seq) begin
                m_idle = 1'b1;
            end
            if (push_ok) m_q.push_back({in_last, in_data});
        end
        @(posedge clk);
        #1;
        chk("pio_out", pio_out, m_pio);
        chk("in_ready", {15'h0000, in_ready}, {15'h0000, 1'(m_q.size() < DEPTH)});
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        in_valid = 1'b0;
        pio_in   = 32'h0000_0000;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_pio_out", pio_out, 16'h0000);
        chk("rst_in_ready", {15'h0000, in_ready}, 16'h0001);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 14'h0000;
        in_last  = 1'b0;
        pio_in   = 32'h0000_0000;
        model_reset();
        do_reset();

        // First word from an empty, idle block appears one edge after the push.
        in_valid = 1'b1; in_data = 14'h01A5; in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("first_word", pio_out, 16'h81A5);
        repeat (20) tick();
        chk("hold_no_ack", pio_out, 16'h81A5);
        pio_in[31] = 1'b1;
        repeat (4) tick();
        chk("ack_empty_idle", pio_out, 16'h81A5);

        // Three-word sequence; next word lands three edges after each ACK change.
        do_reset();
        in_valid = 1'b1; in_data = 14'h0001; in_last = 1'b0;
        tick();
        in_data = 14'h0002;
        tick();
        in_data = 14'h3FFF; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("seq_w0", pio_out, 16'h8001);
        pio_in[31] = 1'b1;
        tick(); tick();
        chk("seq_w0_held", pio_out, 16'h8001);
        tick();
        chk("seq_w1", pio_out, 16'h0002);
        pio_in[31] = 1'b0;
        tick(); tick();
        chk("seq_w1_held", pio_out, 16'h0002);
        tick();
        chk("seq_w2", pio_out, 16'hFFFF);
        pio_in[31] = 1'b1;
        repeat (4) tick();

        // Spurious ACK toggles while idle leave the PIO word alone.
        pio_in[31] = 1'b0;
        repeat (6) tick();
        chk("spurious_ack", pio_out, 16'hFFFF);
        pio_in[31] = 1'b1;
        repeat (4) tick();

        // Random producer and HPS behaviour.
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 14'($urandom);
            in_last  = 1'($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) pio_in[31] = m_seq;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            pio_in[31] = m_seq;
            tick();
        end

        // Fill: one word presented plus DEPTH queued, then back-pressure.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 14'($urandom);
            in_last = 1'($urandom_range(0, 1));
            tick();
        end
        chk("full_not_ready", {15'h0000, in_ready}, 16'h0000);
        in_valid   = 1'b0;
        pio_in[31] = m_seq;
        repeat (3) tick();
        tick(); tick();
        chk("ready_after_pop", {15'h0000, in_ready}, 16'h0001);

        // Refill to full while a word is pending, then reset between edges.
        in_valid = 1'b1;
        in_data  = 14'($urandom);
        tick();
        in_valid = 1'b0;
        chk("refull_not_ready", {15'h0000, in_ready}, 16'h0000);
        do_reset();
        repeat (3) tick();
        chk("post_reset_idle", pio_out, 16'h0000);

`ifdef PIO_TX_FLUSH_EN
        // Pending 0x0055 with five queued, flush together with ACK=1.
        in_valid = 1'b1; in_data = 14'h0055; in_last = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_data = 14'($urandom);
            tick();
        end
        in_valid = 1'b0;
        chk("flush_pending", pio_out, 16'h8055);
        pio_in[31] = 1'b1;
        pio_in[30] = 1'b1;
        repeat (3) tick();
        chk("flush_pio", pio_out, 16'h8000);
        chk("flush_ready", {15'h0000, in_ready}, 16'h0001);
        pio_in[30] = 1'b0;
        repeat (4) tick();
        chk("flush_stays_idle", pio_out, 16'h8000);
        in_valid = 1'b1; in_data = 14'h1234; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_flush_word", pio_out, 16'h5234);
        pio_in[31] = 1'b0;
        repeat (5) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
